dmem_arbiter: RTL and testbench

Shares the single-ported data memory between two requesters: the pipeline MEMORY stage and a loader/debug port used for program load and memory inspection.
- Sequences each access as a request/ready transaction against a variable-latency memory.
- Stalls the pipeline while a MEMORY-stage access is in flight.
- Aborts accesses that exceed a timeout.
- Sits between the MEMORY stage and the data memory array.

---
 rtl/dmem_arbiter_if.sv | 57 +++++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Pipe, loader and data-memory signal bundle for dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // MEMORY-stage requester
    logic          p_read;
    logic          p_write;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [DW-1:0] p_rdata;
    logic          p_done;
    logic          stall;
    // loader / debug requester
    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic [DW-1:0] l_rdata;
    logic          l_ack;
    // data memory
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          err;

    // arbiter side
    modport master (
        input  p_read, p_write, p_addr, p_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  mem_rdata, mem_ready,
        output p_rdata, p_done, stall,
        output l_rdata, l_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output err
    );

    // requester / memory side
    modport slave (
        output p_read, p_write, p_addr, p_wdata,
        output l_req, l_we, l_addr, l_wdata,
        output mem_rdata, mem_ready,
        input  p_rdata, p_done, stall,
        input  l_rdata, l_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin arbiter of the MEMORY stage and loader onto a single
//            variable-latency data memory, with pipeline stall and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dmem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_P_BUSY = 2'd1,
        ST_L_BUSY = 2'd2
    } state_t;

    localparam int                 c_cnt_w       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last    = c_cnt_w'(TIMEOUT - 1);
    localparam logic               c_grant_pipe  = 1'b0;
    localparam logic               c_grant_loader = 1'b1;

    state_t               r_state;
    logic                 r_last_grant;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [AW-1:0]        r_mem_addr;
    logic [DW-1:0]        r_mem_wdata;
    logic [DW-1:0]        r_p_rdata;
    logic [DW-1:0]        r_l_rdata;
    logic                 r_p_done;
    logic                 r_l_ack;
    logic                 r_err;

    logic w_p_pend;
    logic w_p_new;
    logic w_l_new;
    logic w_pick_pipe;

    // A requester still asserting during its own completion cycle is the
    // tail of the finished access, not a new one.
    assign w_p_pend    = bus.p_read | bus.p_write;
    assign w_p_new     = w_p_pend & ~r_p_done;
    assign w_l_new     = bus.l_req & ~r_l_ack;
    assign w_pick_pipe = w_p_new & (~w_l_new | (r_last_grant == c_grant_loader));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= c_grant_loader;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_p_rdata    <= '0;
            r_l_rdata    <= '0;
            r_p_done     <= 1'b0;
            r_l_ack      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_p_done <= 1'b0;
            r_l_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_pipe) begin
                        r_state      <= ST_P_BUSY;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= bus.p_write;
                        r_mem_addr   <= bus.p_addr;
                        r_mem_wdata  <= bus.p_wdata;
                        r_last_grant <= c_grant_pipe;
                        r_cnt        <= '0;
                    end else if (w_l_new) begin
                        r_state      <= ST_L_BUSY;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= bus.l_we;
                        r_mem_addr   <= bus.l_addr;
                        r_mem_wdata  <= bus.l_wdata;
                        r_last_grant <= c_grant_loader;
                        r_cnt        <= '0;
                    end
                end
                ST_P_BUSY, ST_L_BUSY: begin
                    // mem_ready takes priority over an expiring timeout
                    if (bus.mem_ready) begin
                        if (!r_mem_we) begin
                            if (r_state == ST_P_BUSY) r_p_rdata <= bus.mem_rdata;
                            else                      r_l_rdata <= bus.mem_rdata;
                        end
                        if (r_state == ST_P_BUSY) r_p_done <= 1'b1;
                        else                      r_l_ack  <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (r_cnt == c_cnt_last) begin
                        if (r_state == ST_P_BUSY) r_p_done <= 1'b1;
                        else                      r_l_ack  <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.p_rdata   = r_p_rdata;
    assign bus.l_rdata   = r_l_rdata;
    assign bus.p_done    = r_p_done;
    assign bus.l_ack     = r_l_ack;
    assign bus.err       = r_err;
    assign bus.stall     = w_p_pend & ~r_p_done;
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a small memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // memory model controls
    int   mem_wait  = 0;
    bit   mem_never = 0;
    int   wcnt      = 0;
    logic [31:0] mem_array [0:15];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) mif ();

    dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    // Responds mem_wait cycles after mem_req rises; contents reload on rst.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                mem_array[i] = (i == 1) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(i));
            mif.mem_ready = 1'b0;
            mif.mem_rdata = '0;
            wcnt = 0;
        end else if (mif.mem_req) begin
            if (!mem_never && wcnt >= mem_wait) begin
                mif.mem_ready = 1'b1;
                if (mif.mem_we) mem_array[mif.mem_addr[5:2]] = mif.mem_wdata;
                else            mif.mem_rdata = mem_array[mif.mem_addr[5:2]];
            end else begin
                mif.mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            mif.mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Drives one pipe access and reports what was seen on the way.
    task automatic run_pipe(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output int req_cyc, output int we_cyc, output int stall_gaps,
                            output logic stall_at_done, output logic extra, output bit timed_out);
        mif.p_read  = ~we;
        mif.p_write = we;
        mif.p_addr  = addr;
        mif.p_wdata = wdata;
        req_cyc = 0; we_cyc = 0; stall_gaps = 0; stall_at_done = 1'b1; timed_out = 1'b1;
        #1;
        if (!mif.stall) stall_gaps++;
        for (int i = 0; i < 60; i++) begin
            step();
            if (mif.p_done) begin
                timed_out     = 1'b0;
                stall_at_done = mif.stall;
                break;
            end
            if (mif.mem_req) req_cyc++;
            if (mif.mem_req && mif.mem_we && mif.mem_addr == addr && mif.mem_wdata == wdata) we_cyc++;
            if (!mif.stall) stall_gaps++;
        end
        step();
        extra = mif.mem_req | mif.p_done;
        mif.p_read  = 1'b0;
        mif.p_write = 1'b0;
    endtask

    // Raises a pipe read and a loader read together; records grant order.
    task automatic run_conflict(input logic [31:0] paddr, input logic [31:0] laddr,
                                output logic [31:0] first_addr, output int pdone_at, output int lack_at);
        bit got_first = 0;
        bit drop_p = 0;
        bit drop_l = 0;
        mif.p_read = 1'b1; mif.p_write = 1'b0; mif.p_addr = paddr;
        mif.l_req  = 1'b1; mif.l_we    = 1'b0; mif.l_addr = laddr;
        first_addr = '1; pdone_at = -1; lack_at = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (drop_p) begin mif.p_read = 1'b0; drop_p = 0; end
            if (drop_l) begin mif.l_req  = 1'b0; drop_l = 0; end
            if (mif.mem_req && !got_first) begin first_addr = mif.mem_addr; got_first = 1; end
            if (mif.p_done) begin pdone_at = i; drop_p = 1; end
            if (mif.l_ack)  begin lack_at  = i; drop_l = 1; end
            if (pdone_at >= 0 && lack_at >= 0) break;
        end
        step();
        mif.p_read = 1'b0;
        mif.l_req  = 1'b0;
    endtask

    task automatic test_reset;
        mif.p_read = 0; mif.p_write = 0; mif.p_addr = '0; mif.p_wdata = '0;
        mif.l_req = 0; mif.l_we = 0; mif.l_addr = '0; mif.l_wdata = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        checks++;
        if ({mif.mem_req, mif.mem_we, mif.p_done, mif.l_ack, mif.stall, mif.err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {mif.mem_req, mif.mem_we, mif.p_done, mif.l_ack, mif.stall, mif.err});
        end
        checks++;
        if (mif.p_rdata !== 32'h0 || mif.l_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", mif.p_rdata, mif.l_rdata);
        end
        checks++;
        if (mif.mem_addr !== 32'h0 || mif.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h/%h expected 0/0", mif.mem_addr, mif.mem_wdata);
        end
    endtask

    task automatic test_pipe_read;
        int req_cyc, we_cyc, gaps; logic sdone, extra; bit to;
        mem_wait = 1; mem_never = 0;
        run_pipe(1'b0, 32'h4, 32'h0, req_cyc, we_cyc, gaps, sdone, extra, to);
        checks++;
        if (to || req_cyc != 2) begin
            errors++;
            $display("FAIL read_req_cycles: got %0d (timeout=%0d) expected 2", req_cyc, to);
        end
        checks++;
        if (mif.p_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL read_data: got %h expected 12345678", mif.p_rdata);
        end
        checks++;
        if (gaps != 0 || sdone !== 1'b0) begin
            errors++;
            $display("FAIL read_stall: got gaps=%0d stall_at_done=%b expected 0/0", gaps, sdone);
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++;
            $display("FAIL read_single_done: got %b expected 0", extra);
        end
    endtask

    task automatic test_pipe_write;
        int req_cyc, we_cyc, gaps; logic sdone, extra; bit to;
        mem_wait = 0;
        run_pipe(1'b1, 32'h4, 32'hDEAD_BEEF, req_cyc, we_cyc, gaps, sdone, extra, to);
        checks++;
        if (to || req_cyc != 1 || we_cyc != 1) begin
            errors++;
            $display("FAIL write_bus: got req=%0d we=%0d expected 1/1", req_cyc, we_cyc);
        end
        checks++;
        if (mif.p_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_rdata_hold: got %h expected 12345678", mif.p_rdata);
        end
        run_pipe(1'b0, 32'h4, 32'h0, req_cyc, we_cyc, gaps, sdone, extra, to);
        checks++;
        if (to || mif.p_rdata !== 32'hDEAD_BEEF || req_cyc != 1) begin
            errors++;
            $display("FAIL write_readback: got %h req=%0d expected deadbeef req=1", mif.p_rdata, req_cyc);
        end
    endtask

    task automatic test_conflict;
        logic [31:0] first; int pd, la;
        int req_cyc, we_cyc, gaps; logic sdone, extra; bit to;
        do_reset();
        mem_wait = 0;
        run_conflict(32'h8, 32'hC, first, pd, la);
        checks++;
        if (first !== 32'h8 || pd != 1 || la != 3) begin
            errors++;
            $display("FAIL conflict_first: got addr=%h pd=%0d la=%0d expected 8/1/3", first, pd, la);
        end
        checks++;
        if (mif.p_rdata !== 32'hC0DE_0002 || mif.l_rdata !== 32'hC0DE_0003) begin
            errors++;
            $display("FAIL conflict_data: got %h/%h expected c0de0002/c0de0003", mif.p_rdata, mif.l_rdata);
        end
        run_conflict(32'h10, 32'h14, first, pd, la);
        checks++;
        if (first !== 32'h10 || !(pd >= 0 && la > pd)) begin
            errors++;
            $display("FAIL conflict_repeat: got addr=%h pd=%0d la=%0d expected 10, pipe first", first, pd, la);
        end
        run_pipe(1'b0, 32'h8, 32'h0, req_cyc, we_cyc, gaps, sdone, extra, to);
        run_conflict(32'h10, 32'h14, first, pd, la);
        checks++;
        if (first !== 32'h14 || !(la >= 0 && pd > la)) begin
            errors++;
            $display("FAIL conflict_rr: got addr=%h pd=%0d la=%0d expected 14, loader first", first, pd, la);
        end
    endtask

    task automatic test_loader_busy;
        int ack_at = -1;
        int pd_at = -1;
        int gaps = 0;
        bit drop_l = 0;
        logic sdone = 1'b1;
        mem_wait = 4;
        mif.l_req = 1'b1; mif.l_we = 1'b1; mif.l_addr = 32'h20; mif.l_wdata = 32'h55AA_55AA;
        step();
        step();
        mif.p_read = 1'b1; mif.p_addr = 32'h20;
        #1;
        checks++;
        if (mif.stall !== 1'b1) begin
            errors++;
            $display("FAIL busy_stall_rise: got %b expected 1", mif.stall);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            if (drop_l) begin mif.l_req = 1'b0; mif.l_we = 1'b0; drop_l = 0; end
            if (mif.l_ack) begin ack_at = i; drop_l = 1; end
            if (mif.p_done) begin pd_at = i; sdone = mif.stall; break; end
            if (!mif.stall) gaps++;
        end
        step();
        mif.p_read = 1'b0;
        checks++;
        if (ack_at != 3 || pd_at != 9) begin
            errors++;
            $display("FAIL busy_order: got ack=%0d done=%0d expected 3/9", ack_at, pd_at);
        end
        checks++;
        if (gaps != 0 || sdone !== 1'b0) begin
            errors++;
            $display("FAIL busy_stall_hold: got gaps=%0d stall_at_done=%b expected 0/0", gaps, sdone);
        end
        checks++;
        if (mif.p_rdata !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL busy_data: got %h expected 55aa55aa", mif.p_rdata);
        end
    endtask

    task automatic test_timeout_boundary;
        int req_cyc, we_cyc, gaps; logic sdone, extra; bit to;
        mem_wait = 15;
        run_pipe(1'b0, 32'hC, 32'h0, req_cyc, we_cyc, gaps, sdone, extra, to);
        checks++;
        if (to || req_cyc != 16 || mif.err !== 1'b0 || mif.p_rdata !== 32'hC0DE_0003) begin
            errors++;
            $display("FAIL ready_beats_timeout: got req=%0d err=%b data=%h expected 16/0/c0de0003",
                     req_cyc, mif.err, mif.p_rdata);
        end
    endtask

    task automatic test_timeout;
        int req_cyc, we_cyc, gaps; logic sdone, extra; bit to;
        mem_never = 1;
        run_pipe(1'b0, 32'h10, 32'h0, req_cyc, we_cyc, gaps, sdone, extra, to);
        checks++;
        if (to || req_cyc != 16) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d (no done=%0d) expected 16", req_cyc, to);
        end
        checks++;
        if (mif.err !== 1'b1 || mif.p_rdata !== 32'hC0DE_0003 || sdone !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got err=%b data=%h stall=%b expected 1/c0de0003/0",
                     mif.err, mif.p_rdata, sdone);
        end
        repeat (3) step();
        checks++;
        if (mif.err !== 1'b1 || mif.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b req=%b expected 1/0", mif.err, mif.mem_req);
        end
        mem_never = 0;
    endtask

    task automatic test_reset_mid;
        bit done = 0;
        int early_done = 0;
        mem_never = 1;
        mif.p_read = 1'b1; mif.p_addr = 32'h4;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (mif.mem_req !== 1'b0 || mif.err !== 1'b0 || mif.p_done !== 1'b0 || mif.stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got req=%b err=%b done=%b stall=%b expected 0/0/0/1",
                     mif.mem_req, mif.err, mif.p_done, mif.stall);
        end
        mem_never = 0; mem_wait = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mif.p_done) begin
                done = 1;
                if (i < 1) early_done++;
                break;
            end
        end
        step();
        mif.p_read = 1'b0;
        checks++;
        if (!done || early_done != 0 || mif.p_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_reissue: got done=%0d early=%0d data=%h expected 1/0/12345678",
                     done, early_done, mif.p_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_pipe_read();
        test_pipe_write();
        test_conflict();
        test_loader_busy();
        test_timeout_boundary();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
`default_nettype wire
